multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL provide the following ports (name, direction, width, meaning), clock and reset first:
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high; forces FETCH.
REQ-004 opcode  in  6  instruction[31:26] from the instruction register; sampled in DECODE only.
REQ-005 zero  in  1  ALU zero flag; used in BEQ/BNE states.
REQ-006 mem_ready  in  1  memory handshake; 1 = access completes this cycle.
REQ-007 pc_write  out  1  PC load enable (unconditional or branch-qualified).
REQ-008 iord  out  1  memory address select (0 = PC, 1 = ALUOut).
REQ-009 mem_read, mem_write, ir_write  out  1 each  memory read, memory write and instruction-register load strobes.
REQ-010 reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  register-file and ALU source controls.
REQ-011 alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
REQ-012 alu_op  out  2  to ALU decoder: 00 = ADD, 01 = SUB, 10 = funct-decoded.
REQ-013 pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 illegal  out  1  one-cycle pulse on unsupported opcode.
REQ-015 state  out  4  current state encoding (debug).

Function
REQ-016 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQ=8, BNE=9, ADDIEX=10, ADDIWB=11, JUMP=12; unused codes SHALL go to FETCH.
REQ-017 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write SHALL be 1 only while mem_ready=1; stay in FETCH until mem_ready=1, then DECODE.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: 000000->REX, 100011 or 101011->MEMADR, 000100->BEQ, 000101->BNE, 001000->ADDIEX, 000010->JUMP (see REQ-029), other->FETCH with illegal=1 for that cycle.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD for opcode 100011, MEMWR for 101011 (opcode held stable by the IR).
REQ-020 MEMRD: mem_read=1, iord=1; hold until mem_ready=1, then MEMWB.
REQ-021 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-022 MEMWR: mem_write=1, iord=1; hold until mem_ready=1, then FETCH.
REQ-023 REX: alu_src_a=1, alu_src_b=00, alu_op=10; next RWB. RWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-024 BEQ/BNE: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_write SHALL equal zero (BEQ) or ~zero (BNE) in that cycle; next FETCH.
REQ-025 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-026 Every output not listed for a state SHALL be 0 in that state; outputs are combinational from state, mem_ready and zero.
REQ-027 Latency with mem_ready tied 1: R-type and ADDI 4 cycles, LW 5, SW 4, branch 3, jump 3.

Reset
REQ-028 While reset=1 state SHALL be FETCH asynchronously; on release the first rising edge evaluates FETCH; reset mid-wait SHALL abandon the access, and mem_write SHALL drop to 0 combinationally.

Configuration
REQ-029 Macro MULTICYCLE_JUMP_EN: defined -> opcode 000010 goes DECODE->JUMP, JUMP asserts pc_write=1, pc_source=10, next FETCH; undefined -> JUMP state absent, 000010 treated as illegal (illegal pulse, return to FETCH).

Verification
REQ-030 mem_ready=1, opcode 000000 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; alu_op=10 in state 6.
REQ-031 LW (100011) with mem_ready low 3 cycles in MEMRD -> mem_read=1, iord=1 held 4 cycles, MEMWB reached only after mem_ready=1.
REQ-032 BEQ with zero=1 -> pc_write=1, pc_source=01 in state 8; BNE with zero=1 -> pc_write=0 in state 9.
REQ-033 opcode 111111 in DECODE -> illegal=1 for one cycle, next state 0, no reg_write/mem_write.
REQ-034 reset asserted during MEMWR wait -> state=0 and mem_write=0 immediately without clock edge.
REQ-035 opcode 000010 -> with MULTICYCLE_JUMP_EN: states 0,1,12,0 with pc_write=1, pc_source=10; without: illegal=1, states 0,1,0.

Source files
------------

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Function : Main control FSM for a multicycle MIPS-style datapath with a
//            ready-handshaked memory. Optional macro MULTICYCLE_JUMP_EN adds
//            the JUMP state (opcode 000010); without it that opcode is illegal.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] c_op_j     = 6'b000010;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_ADDIEX = 4'd10,
`ifdef MULTICYCLE_JUMP_EN
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
`else
    S_ADDIWB = 4'd11
`endif
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

  // Every output defaults to 0 so each state only lists what it drives.
  always_comb begin
    w_next     = S_FETCH;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          c_op_rtype:        w_next = S_REX;
          c_op_lw, c_op_sw:  w_next = S_MEMADR;
          c_op_beq:          w_next = S_BEQ;
          c_op_bne:          w_next = S_BNE;
          c_op_addi:         w_next = S_ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
          c_op_j:            w_next = S_JUMP;
`endif
          default: begin
            w_next  = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end

      // The IR still holds the instruction, so opcode is stable here.
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == c_op_sw) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        w_next   = mem_ready ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        w_next    = mem_ready ? S_FETCH : S_MEMWR;
      end

      S_REX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_RWB;
      end

      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = S_FETCH;
      end

      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_write  = zero;
        w_next    = S_FETCH;
      end

      S_BNE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_write  = ~zero;
        w_next    = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end

`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        w_next    = S_FETCH;
      end
`endif

      default: w_next = S_FETCH;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Function : Directed self-checking bench for multicycle_control.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #12;
    check("reset_state", 32'(state), 0);
    check("reset_memwrite", 32'(mem_write), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // FETCH stalls while memory is not ready
    mem_ready = 1'b0;
    #1;
    check("fetch_wait_irwrite", 32'(ir_write), 0);
    check("fetch_wait_pcwrite", 32'(pc_write), 0);
    check("fetch_wait_memread", 32'(mem_read), 1);
    step();
    check("fetch_wait_state", 32'(state), 0);

    // R-type: 0,1,6,7,0
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    #1;
    check("fetch_irwrite", 32'(ir_write), 1);
    check("fetch_pcwrite", 32'(pc_write), 1);
    check("fetch_srcb", 32'(alu_src_b), 1);
    step();
    check("r_decode_state", 32'(state), 1);
    check("r_decode_srcb", 32'(alu_src_b), 3);
    check("r_decode_regwrite", 32'(reg_write), 0);
    step();
    check("rex_state", 32'(state), 6);
    check("rex_aluop", 32'(alu_op), 2);
    check("rex_srca", 32'(alu_src_a), 1);
    check("rex_regwrite", 32'(reg_write), 0);
    step();
    check("rwb_state", 32'(state), 7);
    check("rwb_regwrite", 32'(reg_write), 1);
    check("rwb_regdst", 32'(reg_dst), 1);
    step();
    check("r_done_state", 32'(state), 0);

    // LW with three wait cycles in MEMRD
    opcode = 6'b100011;
    step();
    step();
    check("lw_memadr_state", 32'(state), 2);
    check("lw_memadr_srcb", 32'(alu_src_b), 2);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("lw_wait_state", 32'(state), 3);
      check("lw_wait_memread", 32'(mem_read), 1);
      check("lw_wait_iord", 32'(iord), 1);
      step();
    end
    check("lw_wait_state_3", 32'(state), 3);
    mem_ready = 1'b1;
    #1;
    check("lw_ready_memread", 32'(mem_read), 1);
    step();
    check("memwb_state", 32'(state), 4);
    check("memwb_regwrite", 32'(reg_write), 1);
    check("memwb_memtoreg", 32'(mem_to_reg), 1);
    check("memwb_regdst", 32'(reg_dst), 0);
    step();
    check("lw_done_state", 32'(state), 0);

    // BEQ taken / not taken
    opcode = 6'b000100;
    zero   = 1'b1;
    step();
    step();
    check("beq_state", 32'(state), 8);
    check("beq_pcwrite_z1", 32'(pc_write), 1);
    check("beq_pcsource", 32'(pc_source), 1);
    check("beq_aluop", 32'(alu_op), 1);
    zero = 1'b0;
    #1;
    check("beq_pcwrite_z0", 32'(pc_write), 0);
    step();
    check("beq_done_state", 32'(state), 0);

    // BNE with zero=1 does not write PC
    opcode = 6'b000101;
    zero   = 1'b1;
    step();
    step();
    check("bne_state", 32'(state), 9);
    check("bne_pcwrite_z1", 32'(pc_write), 0);
    zero = 1'b0;
    #1;
    check("bne_pcwrite_z0", 32'(pc_write), 1);
    step();
    check("bne_done_state", 32'(state), 0);

    // ADDI: 0,1,10,11,0
    opcode = 6'b001000;
    step();
    step();
    check("addiex_state", 32'(state), 10);
    check("addiex_srcb", 32'(alu_src_b), 2);
    step();
    check("addiwb_state", 32'(state), 11);
    check("addiwb_regwrite", 32'(reg_write), 1);
    check("addiwb_regdst", 32'(reg_dst), 0);
    step();
    check("addi_done_state", 32'(state), 0);

    // Unsupported opcode
    opcode = 6'b111111;
    step();
    check("ill_decode_state", 32'(state), 1);
    check("ill_pulse", 32'(illegal), 1);
    check("ill_regwrite", 32'(reg_write), 0);
    check("ill_memwrite", 32'(mem_write), 0);
    step();
    check("ill_next_state", 32'(state), 0);
    check("ill_cleared", 32'(illegal), 0);

    // Jump (build-dependent)
    opcode = 6'b000010;
    step();
    check("j_decode_state", 32'(state), 1);
`ifdef MULTICYCLE_JUMP_EN
    check("j_illegal", 32'(illegal), 0);
    step();
    check("jump_state", 32'(state), 12);
    check("jump_pcwrite", 32'(pc_write), 1);
    check("jump_pcsource", 32'(pc_source), 2);
    step();
    check("jump_done_state", 32'(state), 0);
`else
    check("j_illegal", 32'(illegal), 1);
    step();
    check("j_ill_next_state", 32'(state), 0);
`endif

    // SW stalled in MEMWR, then asynchronous reset mid-cycle
    opcode = 6'b101011;
    step();
    step();
    check("sw_memadr_state", 32'(state), 2);
    mem_ready = 1'b0;
    step();
    check("memwr_state", 32'(state), 5);
    check("memwr_memwrite", 32'(mem_write), 1);
    check("memwr_iord", 32'(iord), 1);
    step();
    check("memwr_hold_state", 32'(state), 5);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_state", 32'(state), 0);
    check("async_reset_memwrite", 32'(mem_write), 0);
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    step();
    check("post_reset_state", 32'(state), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
